video_scanline_dimmer: RTL and testbench

VIDEO_SCANLINE_DIMMER -- requirements
Module: video_scanline_dimmer

---
 rtl/video_scanline_dimmer_if.sv | 18 +
 rtl/video_scanline_dimmer.sv | 91 +++++++++
 tb/tb_video_scanline_dimmer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/video_scanline_dimmer_if.sv
// video_scanline_dimmer_if: video in/out bundle for the scanline dimmer
//   master: drives R/G/B and the timing inputs, receives the dimmed colour,
//           the delayed timing and line_odd
//   slave : the dimmer side of the same bundle
interface video_scanline_dimmer_if;
    logic [7:0] R, G, B;
    logic       HSync, VSync, HBlank, VBlank;
    logic [7:0] R_OUT, G_OUT, B_OUT;
    logic       HS_OUT, VS_OUT, HB_OUT, VB_OUT, line_odd;
    modport master (
        output R, G, B, HSync, VSync, HBlank, VBlank,
        input  R_OUT, G_OUT, B_OUT, HS_OUT, VS_OUT, HB_OUT, VB_OUT, line_odd
    );
    modport slave (
        input  R, G, B, HSync, VSync, HBlank, VBlank,
        output R_OUT, G_OUT, B_OUT, HS_OUT, VS_OUT, HB_OUT, VB_OUT, line_odd
    );
endinterface

// File: rtl/video_scanline_dimmer.sv
// video_scanline_dimmer: two-stage pipeline that darkens alternate video lines
//   clk_vid   : video clock, rising edge
//   reset     : asynchronous active-high reset
//   ce_pix    : pixel enable, every register holds while low
//   scan_mode : dim level 0 off, 1 75%, 2 50%, 3 25%, latched on VSync leading edge
//   vid       : colour/timing in, dimmed colour/delayed timing/line_odd out
module video_scanline_dimmer #(
    parameter bit HS_ACTIVE_HIGH = 1'b1
) (
    input  logic                          clk_vid,
    input  logic                          reset,
    input  logic                          ce_pix,
    input  logic [1:0]                    scan_mode,
    video_scanline_dimmer_if.slave        vid
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, hb, vb;
    } pix_t;
    localparam logic SYNC_IDLE = !HS_ACTIVE_HIGH;
    localparam pix_t PIX_RST = '{r: 8'd0, g: 8'd0, b: 8'd0, hs: SYNC_IDLE, vs: SYNC_IDLE, hb: 1'b1, vb: 1'b1};
    state_t     state_q, state_d;
    pix_t       s1_q, s1_d, out_q, out_d;
    logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic       line_odd_q, line_odd_d;
    logic [1:0] mode_q, mode_d;
    logic       hs_edge, vs_edge, blank, dim_en;
    function automatic logic [7:0] dim(input logic [7:0] x, input logic [1:0] m);
        return m == 2'd1 ? x - (x >> 2) : m == 2'd2 ? x >> 1 : m == 2'd3 ? x >> 2 : x;
    endfunction
    // The dim decision uses the line state as updated by this pixel's own edges,
    // so line_odd leaves the pipeline together with the pixel it governed.
    always_comb begin
        hs_edge    = s1_q.hs == HS_ACTIVE_HIGH && hs_prev_q == SYNC_IDLE;
        vs_edge    = s1_q.vs == HS_ACTIVE_HIGH && vs_prev_q == SYNC_IDLE;
        state_d    = state_q;
        mode_d     = mode_q;
        line_odd_d = line_odd_q;
        s1_d       = s1_q;
        out_d      = out_q;
        hs_prev_d  = hs_prev_q;
        vs_prev_d  = vs_prev_q;
        blank      = s1_q.hb || s1_q.vb;
        dim_en     = 1'b0;
        if (ce_pix) begin
            s1_d      = '{r: vid.R, g: vid.G, b: vid.B, hs: vid.HSync, vs: vid.VSync, hb: vid.HBlank, vb: vid.VBlank};
            hs_prev_d = s1_q.hs;
            vs_prev_d = s1_q.vs;
            if (vs_edge) begin
                state_d    = ACTIVE;
                mode_d     = scan_mode;
                line_odd_d = 1'b0;
            end else if (hs_edge) begin
                line_odd_d = !line_odd_q;
            end
            dim_en = state_d == ACTIVE && line_odd_d && mode_d != 2'd0;
            out_d  = '{r: blank ? 8'd0 : dim_en ? dim(s1_q.r, mode_d) : s1_q.r,
                       g: blank ? 8'd0 : dim_en ? dim(s1_q.g, mode_d) : s1_q.g,
                       b: blank ? 8'd0 : dim_en ? dim(s1_q.b, mode_d) : s1_q.b,
                       hs: s1_q.hs, vs: s1_q.vs, hb: s1_q.hb, vb: s1_q.vb};
        end
    end
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'd0;
            line_odd_q <= 1'b0;
            s1_q       <= PIX_RST;
            out_q      <= PIX_RST;
            hs_prev_q  <= SYNC_IDLE;
            vs_prev_q  <= SYNC_IDLE;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            line_odd_q <= line_odd_d;
            s1_q       <= s1_d;
            out_q      <= out_d;
            hs_prev_q  <= hs_prev_d;
            vs_prev_q  <= vs_prev_d;
        end
    end
    assign vid.R_OUT    = out_q.r;
    assign vid.G_OUT    = out_q.g;
    assign vid.B_OUT    = out_q.b;
    assign vid.HS_OUT   = out_q.hs;
    assign vid.VS_OUT   = out_q.vs;
    assign vid.HB_OUT   = out_q.hb;
    assign vid.VB_OUT   = out_q.vb;
    assign vid.line_odd = line_odd_q;
endmodule

// File: tb/tb_video_scanline_dimmer.sv
// tb_video_scanline_dimmer: directed self-checking bench for video_scanline_dimmer
module tb_video_scanline_dimmer;
    logic       clk_vid = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [1:0] scan_mode;
    int         tests = 0;
    int         fails = 0;
    video_scanline_dimmer_if vif();
    video_scanline_dimmer #(.HS_ACTIVE_HIGH(1'b1)) dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .scan_mode(scan_mode), .vid(vif)
    );
    always #5 clk_vid = ~clk_vid;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_vid);
            @(negedge clk_vid);
        end
    endtask
    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        vif.R = r;
        vif.G = g;
        vif.B = b;
    endtask
    task automatic vs_pulse();
        vif.VSync = 1'b1;
        tick();
        vif.VSync = 1'b0;
        tick();
    endtask
    task automatic hs_pulse();
        vif.HSync = 1'b1;
        tick();
        vif.HSync = 1'b0;
        tick();
    endtask
    initial begin
        reset = 1'b1;
        ce_pix = 1'b1;
        scan_mode = 2'd2;
        pix(8'h80, 8'h80, 8'h80);
        vif.HSync = 1'b0;
        vif.VSync = 1'b0;
        vif.HBlank = 1'b0;
        vif.VBlank = 1'b0;
        @(negedge clk_vid);
        chk("rst_r", vif.R_OUT, 8'h00);
        chk("rst_hb", vif.HB_OUT, 8'h01);
        chk("rst_vb", vif.VB_OUT, 8'h01);
        chk("rst_hs", vif.HS_OUT, 8'h00);
        chk("rst_vs", vif.VS_OUT, 8'h00);
        chk("rst_odd", vif.line_odd, 8'h00);
        reset = 1'b0;
        tick();
        chk("lat1_r", vif.R_OUT, 8'h00);
        chk("lat1_hb", vif.HB_OUT, 8'h01);
        tick();
        chk("idle_r", vif.R_OUT, 8'h80);
        chk("idle_g", vif.G_OUT, 8'h80);
        chk("idle_hb", vif.HB_OUT, 8'h00);
        pix(8'h80, 8'hFF, 8'h03);
        tick(2);
        chk("idle_g2", vif.G_OUT, 8'hFF);
        vs_pulse();
        chk("vs_out", vif.VS_OUT, 8'h01);
        chk("vs_odd", vif.line_odd, 8'h00);
        tick(2);
        chk("even0_r", vif.R_OUT, 8'h80);
        hs_pulse();
        chk("l1_hs", vif.HS_OUT, 8'h01);
        chk("l1_odd", vif.line_odd, 8'h01);
        chk("l1_r0", vif.R_OUT, 8'h40);
        tick();
        chk("l1_r", vif.R_OUT, 8'h40);
        chk("l1_g", vif.G_OUT, 8'h7F);
        chk("l1_b", vif.B_OUT, 8'h01);
        hs_pulse();
        chk("l2_odd", vif.line_odd, 8'h00);
        chk("l2_r", vif.R_OUT, 8'h80);
        chk("l2_g", vif.G_OUT, 8'hFF);
        chk("l2_b", vif.B_OUT, 8'h03);
        scan_mode = 2'd1;
        pix(8'hFF, 8'hFF, 8'hFF);
        vs_pulse();
        hs_pulse();
        chk("m1_r", vif.R_OUT, 8'hC0);
        scan_mode = 2'd0;
        vs_pulse();
        hs_pulse();
        chk("m0_odd", vif.line_odd, 8'h01);
        chk("m0_r", vif.R_OUT, 8'hFF);
        scan_mode = 2'd3;
        tick(3);
        chk("mid_r", vif.R_OUT, 8'hFF);
        hs_pulse();
        hs_pulse();
        chk("mid_odd", vif.line_odd, 8'h01);
        chk("mid_r2", vif.R_OUT, 8'hFF);
        vs_pulse();
        hs_pulse();
        chk("m3_r", vif.R_OUT, 8'h3F);
        chk("m3_g", vif.G_OUT, 8'h3F);
        vif.HBlank = 1'b1;
        tick(2);
        chk("hb_r", vif.R_OUT, 8'h00);
        chk("hb_out", vif.HB_OUT, 8'h01);
        vif.HBlank = 1'b0;
        vif.VBlank = 1'b1;
        tick(2);
        chk("vb_g", vif.G_OUT, 8'h00);
        vif.VBlank = 1'b0;
        tick(2);
        chk("unblank_b", vif.B_OUT, 8'h3F);
        hs_pulse();
        chk("pre_co_odd", vif.line_odd, 8'h00);
        vif.HSync = 1'b1;
        vif.VSync = 1'b1;
        tick();
        vif.HSync = 1'b0;
        vif.VSync = 1'b0;
        tick();
        chk("co_odd", vif.line_odd, 8'h00);
        chk("co_hs", vif.HS_OUT, 8'h01);
        chk("co_vs", vif.VS_OUT, 8'h01);
        chk("co_r", vif.R_OUT, 8'hFF);
        tick();
        chk("co_odd2", vif.line_odd, 8'h00);
        pix(8'h20, 8'hFF, 8'hFF);
        tick();
        chk("ce_first", vif.R_OUT, 8'hFF);
        ce_pix = 1'b0;
        pix(8'h55, 8'hFF, 8'hFF);
        tick(2);
        chk("ce_hold", vif.R_OUT, 8'hFF);
        pix(8'h20, 8'hFF, 8'hFF);
        ce_pix = 1'b1;
        tick();
        chk("ce_lat2", vif.R_OUT, 8'h20);
        ce_pix = 1'b0;
        tick(2);
        vif.HSync = 1'b1;
        ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        tick(2);
        chk("ce_hs_hold", vif.HS_OUT, 8'h00);
        vif.HSync = 1'b0;
        ce_pix = 1'b1;
        tick();
        chk("ce_odd", vif.line_odd, 8'h01);
        chk("ce_dim", vif.R_OUT, 8'h08);
        ce_pix = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mrst_r", vif.R_OUT, 8'h00);
        chk("mrst_hb", vif.HB_OUT, 8'h01);
        chk("mrst_vb", vif.VB_OUT, 8'h01);
        chk("mrst_hs", vif.HS_OUT, 8'h00);
        chk("mrst_odd", vif.line_odd, 8'h00);
        @(negedge clk_vid);
        reset = 1'b0;
        ce_pix = 1'b1;
        pix(8'hFF, 8'hFF, 8'hFF);
        tick(2);
        chk("post_r", vif.R_OUT, 8'hFF);
        hs_pulse();
        chk("post_odd", vif.line_odd, 8'h01);
        chk("post_nodim", vif.R_OUT, 8'hFF);
        tick();
        chk("post_nodim2", vif.G_OUT, 8'hFF);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
